// File: rtl/asm_updown_counter.sv
// Parametrised modulo up/down counter with preset, range-checked load,
// wrap/saturate modes and a RUN/HALT sequencer.
module asm_updown_counter #(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 16,
  parameter int PRESET_VAL = MODULUS - 1,
  parameter bit SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             pre,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cnt_en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             roll,
  output logic             halted,
  output logic             load_err
);

  typedef enum logic {RUN, HALT} state_t;

  // MODULUS may equal 2**WIDTH, so the range check needs one extra bit.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRESET  = WIDTH'(PRESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t state;
  logic   in_range;
  logic   at_top;
  logic   at_bottom;

  assign in_range  = {1'b0, data_in} < MOD_EXT;
  assign at_top    = (data_out == MAX_VAL);
  assign at_bottom = (data_out == '0);
  assign tc        = (up_dn && at_top) || (!up_dn && at_bottom);
  assign halted    = (state == HALT);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      data_out <= '0;
      roll     <= 1'b0;
      load_err <= 1'b0;
      state    <= RUN;
    end else begin
      roll     <= 1'b0;
      load_err <= 1'b0;
      if (pre) begin
        data_out <= PRESET;
        state    <= RUN;
      end else if (en) begin
        state <= RUN;
        if (in_range) begin
          data_out <= data_in;
        end else begin
          data_out <= MAX_VAL;
          load_err <= 1'b1;
        end
      end else if (cnt_en && state == RUN) begin
        // Range ends either wrap or park the counter in HALT until reloaded.
        if (up_dn) begin
          if (!at_top) begin
            data_out <= data_out + 1'b1;
          end else begin
            roll <= 1'b1;
            if (SATURATE) state <= HALT;
            else          data_out <= '0;
          end
        end else begin
          if (!at_bottom) begin
            data_out <= data_out - 1'b1;
          end else begin
            roll <= 1'b1;
            if (SATURATE) state <= HALT;
            else          data_out <= MAX_VAL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_asm_updown_counter.sv
// Scoreboard bench for asm_updown_counter: three instances cover MODULUS=10
// wrap, MODULUS=10 saturate and the default 16-state configuration.
module tb_asm_updown_counter;

  typedef struct packed {
    logic [3:0] d;
    logic       tc;
    logic       roll;
    logic       halted;
    logic       lerr;
  } obs_t;

  typedef struct {
    int   idx;
    obs_t v;
  } exp_t;

  logic       clk;
  logic [2:0] clear, pre, en, cnt_en, up_dn;
  logic [3:0] data_in [3];
  logic [3:0] data_out [3];
  logic [2:0] tc, roll, halted, load_err;

  exp_t exp_q[$];
  int   tests;
  int   failed;

  asm_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .clear(clear[0]), .pre(pre[0]), .en(en[0]), .data_in(data_in[0]),
    .cnt_en(cnt_en[0]), .up_dn(up_dn[0]), .data_out(data_out[0]), .tc(tc[0]),
    .roll(roll[0]), .halted(halted[0]), .load_err(load_err[0])
  );

  asm_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .clear(clear[1]), .pre(pre[1]), .en(en[1]), .data_in(data_in[1]),
    .cnt_en(cnt_en[1]), .up_dn(up_dn[1]), .data_out(data_out[1]), .tc(tc[1]),
    .roll(roll[1]), .halted(halted[1]), .load_err(load_err[1])
  );

  asm_updown_counter dut_def (
    .clk(clk), .clear(clear[2]), .pre(pre[2]), .en(en[2]), .data_in(data_in[2]),
    .cnt_en(cnt_en[2]), .up_dn(up_dn[2]), .data_out(data_out[2]), .tc(tc[2]),
    .roll(roll[2]), .halted(halted[2]), .load_err(load_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_obs(int i);
    obs_t o;
    o = {data_out[i], tc[i], roll[i], halted[i], load_err[i]};
    return o;
  endfunction

  function automatic logic [3:0] max_of(int i);
    return (i == 2) ? 4'd15 : 4'd9;
  endfunction

  // Expected tc is derived from the expected count and the direction held
  // on the DUT's inputs when the sample is taken.
  task automatic push_exp(int i, int d, int r, int h, int le);
    exp_t e;
    logic t;
    t = (up_dn[i] && 4'(d) == max_of(i)) || (!up_dn[i] && 4'(d) == 4'd0);
    e.idx = i;
    e.v   = {4'(d), t, 1'(r), 1'(h), 1'(le)};
    exp_q.push_back(e);
  endtask

  task automatic drive(int i, int p, int e, int din, int c, int u,
                       int d, int r, int h, int le);
    pre    = '0;
    en     = '0;
    cnt_en = '0;
    up_dn  = '0;
    for (int k = 0; k < 3; k++) data_in[k] = 4'd0;
    pre[i]     = 1'(p);
    en[i]      = 1'(e);
    cnt_en[i]  = 1'(c);
    up_dn[i]   = 1'(u);
    data_in[i] = 4'(din);
    push_exp(i, d, r, h, le);
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin
          clear = '0;
          repeat (2) @(posedge clk);
          #3;
          for (int i = 0; i < 3; i++) push_exp(i, 0, 0, 0, 0);
        end
        1: begin
          @(negedge clk);
          clear = '1;
          @(posedge clk); #1;
          drive(0, 0, 1, 5, 0, 1, 5, 0, 0, 0);
          @(posedge clk); #1;
        end
        2: begin
          drive(0, 0, 0, 0, 1, 1, 6, 0, 0, 0);
          @(posedge clk); #1;
        end
        3: begin
          #2;
          clear[0] = 1'b0;
          #1;
          push_exp(0, 0, 0, 0, 0);
        end
        4: begin
          @(posedge clk); #1;
          push_exp(0, 0, 0, 0, 0);
        end
        default: begin
          cnt_en[0] = 1'b0;
          @(negedge clk);
          clear[0] = 1'b1;
          @(posedge clk); #1;
          push_exp(0, 0, 0, 0, 0);
        end
      endcase
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = get_obs(e.idx);
        tests++;
        if (o !== e.v) begin
          failed++;
          $display("[TB] FAIL reset step %0d dut %0d: got d=%0d tc=%b roll=%b halted=%b lerr=%b, expected d=%0d tc=%b roll=%b halted=%b lerr=%b",
                   s, e.idx, o.d, o.tc, o.roll, o.halted, o.lerr, e.v.d, e.v.tc, e.v.roll, e.v.halted, e.v.lerr);
        end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    obs_t o;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: drive(0, 0, 1, 7, 0, 1, 7, 0, 0, 0);
        1: drive(0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
        2: drive(0, 0, 0, 0, 1, 1, 9, 0, 0, 0);
        3: drive(0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        4: drive(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        5: drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        6: drive(0, 0, 0, 0, 1, 0, 9, 1, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
      endcase
      @(posedge clk); #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = get_obs(e.idx);
        tests++;
        if (o !== e.v) begin
          failed++;
          $display("[TB] FAIL wrap step %0d: got d=%0d tc=%b roll=%b halted=%b lerr=%b, expected d=%0d tc=%b roll=%b halted=%b lerr=%b",
                   s, o.d, o.tc, o.roll, o.halted, o.lerr, e.v.d, e.v.tc, e.v.roll, e.v.halted, e.v.lerr);
        end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    obs_t o;
    for (int s = 0; s < 12; s++) begin
      case (s)
        0:  drive(1, 0, 1, 8, 0, 1, 8, 0, 0, 0);
        1:  drive(1, 0, 0, 0, 1, 1, 9, 0, 0, 0);
        2:  drive(1, 0, 0, 0, 1, 1, 9, 1, 1, 0);
        3:  drive(1, 0, 0, 0, 1, 1, 9, 0, 1, 0);
        4:  drive(1, 0, 0, 0, 1, 0, 9, 0, 1, 0);
        5:  drive(1, 0, 0, 0, 1, 0, 9, 0, 1, 0);
        6:  drive(1, 0, 1, 3, 1, 0, 3, 0, 0, 0);
        7:  drive(1, 0, 0, 0, 1, 0, 2, 0, 0, 0);
        8:  drive(1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        9:  drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        10: drive(1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        default: drive(1, 1, 0, 0, 1, 0, 9, 0, 0, 0);
      endcase
      @(posedge clk); #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = get_obs(e.idx);
        tests++;
        if (o !== e.v) begin
          failed++;
          $display("[TB] FAIL saturate step %0d: got d=%0d tc=%b roll=%b halted=%b lerr=%b, expected d=%0d tc=%b roll=%b halted=%b lerr=%b",
                   s, o.d, o.tc, o.roll, o.halted, o.lerr, e.v.d, e.v.tc, e.v.roll, e.v.halted, e.v.lerr);
        end
      end
    end
  endtask

  task automatic test_load_range();
    exp_t e;
    obs_t o;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: drive(0, 0, 1, 5,  0, 1, 5, 0, 0, 0);
        1: drive(0, 0, 1, 12, 0, 1, 9, 0, 0, 1);
        2: drive(0, 0, 0, 0,  0, 1, 9, 0, 0, 0);
        3: drive(0, 0, 1, 10, 0, 1, 9, 0, 0, 1);
        4: drive(0, 0, 1, 9,  0, 1, 9, 0, 0, 0);
        5: drive(0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
        6: drive(0, 0, 1, 15, 1, 1, 9, 0, 0, 1);
        default: drive(0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
      endcase
      @(posedge clk); #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = get_obs(e.idx);
        tests++;
        if (o !== e.v) begin
          failed++;
          $display("[TB] FAIL load_range step %0d: got d=%0d tc=%b roll=%b halted=%b lerr=%b, expected d=%0d tc=%b roll=%b halted=%b lerr=%b",
                   s, o.d, o.tc, o.roll, o.halted, o.lerr, e.v.d, e.v.tc, e.v.roll, e.v.halted, e.v.lerr);
        end
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    obs_t o;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: drive(0, 0, 1, 4,  0, 1, 4, 0, 0, 0);
        1: drive(0, 1, 1, 2,  1, 1, 9, 0, 0, 0);
        2: drive(0, 0, 1, 2,  1, 1, 2, 0, 0, 0);
        3: drive(0, 1, 1, 13, 0, 1, 9, 0, 0, 0);
        4: drive(0, 0, 1, 2,  1, 0, 2, 0, 0, 0);
        default: drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      endcase
      @(posedge clk); #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = get_obs(e.idx);
        tests++;
        if (o !== e.v) begin
          failed++;
          $display("[TB] FAIL priority step %0d: got d=%0d tc=%b roll=%b halted=%b lerr=%b, expected d=%0d tc=%b roll=%b halted=%b lerr=%b",
                   s, o.d, o.tc, o.roll, o.halted, o.lerr, e.v.d, e.v.tc, e.v.roll, e.v.halted, e.v.lerr);
        end
      end
    end
  endtask

  task automatic test_defaults();
    exp_t e;
    obs_t o;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: drive(2, 0, 1, 14, 0, 1, 14, 0, 0, 0);
        1: drive(2, 0, 0, 0,  1, 1, 15, 0, 0, 0);
        2: drive(2, 0, 0, 0,  1, 1, 0,  1, 0, 0);
        3: drive(2, 0, 0, 0,  1, 1, 1,  0, 0, 0);
        4: drive(2, 1, 0, 0,  0, 1, 15, 0, 0, 0);
        5: drive(2, 0, 0, 0,  1, 0, 14, 0, 0, 0);
        6: drive(2, 0, 1, 0,  1, 0, 0,  0, 0, 0);
        default: drive(2, 0, 0, 0, 1, 0, 15, 1, 0, 0);
      endcase
      @(posedge clk); #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = get_obs(e.idx);
        tests++;
        if (o !== e.v) begin
          failed++;
          $display("[TB] FAIL defaults step %0d: got d=%0d tc=%b roll=%b halted=%b lerr=%b, expected d=%0d tc=%b roll=%b halted=%b lerr=%b",
                   s, o.d, o.tc, o.roll, o.halted, o.lerr, e.v.d, e.v.tc, e.v.roll, e.v.halted, e.v.lerr);
        end
      end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    clear  = '0;
    pre    = '0;
    en     = '0;
    cnt_en = '0;
    up_dn  = '0;
    for (int k = 0; k < 3; k++) data_in[k] = 4'd0;

    test_reset();
    test_wrap();
    test_saturate();
    test_load_range();
    test_priority();
    test_defaults();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
